axi_rd_burst_sched: RTL
=======================

# axi_rd_burst_sched

Burst scheduler sitting between the register bank and the `axi_mst_read` block in the DDR bandwidth test. It accepts one long read request: a start address plus a total length in beats. It splits that request into AXI INCR bursts of at most 16 beats, and no burst crosses a 4 KB boundary. Each burst is issued by sequencing the read master's START/ADDR/LENGTH/RIDLE register handshake. The block also reports burst count and elapsed cycles for bandwidth measurement.

## Interface
- `DATA_WIDTH`, 64: AXI data width in bits; bytes per beat `BPB = DATA_WIDTH/8`, a power of two, 8..128.
- `MAX_BURST`, 16: maximum beats per burst (AXI3 limit of the read master).
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous, active-high.
- `START_REG` in 1: level request; each rising edge seen in IDLE starts one transfer.
- `ADDR_REG` in 32: start byte address; low `log2(BPB)` bits are ignored (forced to 0).
- `LENGTH_REG` in 32: total beats to read.
- `BUSY_REG` out 1: transfer in progress.
- `DONE_REG` out 1: transfer finished; held until `START_REG` low.
- `NBURST_REG` out 32: bursts issued in the current/last transfer.
- `CYCLES_REG` out 32: cycles spent busy in the current/last transfer; saturates at 0xFFFFFFFF.
- `rd_start` out 1: drives read master `START_REG`.
- `rd_addr` out 32: drives read master `ADDR_REG`.
- `rd_len` out 32: drives read master `LENGTH_REG`; value is always 1..MAX_BURST.
- `rd_idle` in 1: read master `RIDLE_REG`.

## Operation
- States: IDLE, LOAD, CALC, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, FINISH.
- **IDLE**
  - Requires `START_REG`=1 with the previous-cycle `START_REG`=0 (edge register reset to 1, so a START held through reset does not fire).
  - Also requires `rd_idle`=1.
  - Then go to LOAD.
- **LOAD**: latch `cur_addr` = `ADDR_REG` & ~(BPB-1) and `rem` = `LENGTH_REG`; clear NBURST and CYCLES. If `rem`=0, go to FINISH; otherwise go to CALC.
- **CALC**: `btb = (4096 - cur_addr[11:0]) / BPB`, computed in 13 bits. `blen = min(MAX_BURST, rem, btb)`. Register `blen` into `rd_len` and `cur_addr` into `rd_addr`. Go to ISSUE.
- **ISSUE**: assert `rd_start`; go to WAIT_ACK.
- **WAIT_ACK**: hold `rd_start`=1 until `rd_idle`=0, then deassert `rd_start` and go to WAIT_DONE.
- **WAIT_DONE**: wait for `rd_idle`=1, then go to NEXT.
- **NEXT**: `cur_addr += blen*BPB` (mod 2^32); `rem -= blen`; NBURST++. If `rem`=0, go to FINISH; otherwise go to CALC.
- **FINISH**: assert DONE; go to IDLE once `START_REG`=0. DONE clears on that exit.
- `rd_addr`/`rd_len` are stable from CALC until the next CALC.
- BUSY=1 in every state except IDLE and FINISH.
- CYCLES increments on every cycle in which BUSY=1.
- Address wrap past 0xFFFFFFFF: `cur_addr[11:0]`=0 gives btb=4096/BPB, so bursts continue from 0x00000000.

## Timing
- Reset values: all outputs 0, state IDLE.
- Latency:
  - START edge to `rd_start`=1: 3 cycles (LOAD, CALC, ISSUE).
  - `rd_idle` rise in WAIT_DONE to the next `rd_start`: 3 cycles (NEXT, CALC, ISSUE).
- Handshake rules:
  - `rd_start` never drops before `rd_idle` has been seen low.
  - A new burst is never issued while `rd_idle`=0.
- `START_REG` dropping mid-transfer is ignored; the transfer always completes.
- Reset mid-transfer: everything returns to reset values on the next edge. The read master finishes its burst independently. IDLE waits for `rd_idle`=1 before starting again.

## Structure
- Package `axi_sched_pkg`: `state_t` enum, `BOUNDARY_BYTES`=4096, and a `clog2`-based byte-shift helper.
- Sub-module `burst_len_calc`, purely combinational (`cur_addr`, `rem` to `blen`). It is instantiated once and registered in CALC.

## Test plan
All scenarios use DATA_WIDTH=64 and a behavioural read-master model whose `rd_idle` low time is randomized.
- ADDR=0x0, LEN=40 -> bursts (0x000,16), (0x080,16), (0x100,8); NBURST=3; DONE=1.
- ADDR=0xFC0, LEN=20 -> bursts (0xFC0,8), (0x1000,12); no burst crosses 0x1000.
- LEN=0 -> DONE=1 within 2 cycles of START; `rd_start` never asserted; NBURST=0, CYCLES=1.
- ADDR=0x13, LEN=1 -> single burst (0x10,1).
- ADDR=0xFFFFFFF0, LEN=4 -> bursts (0xFFFFFFF0,2), (0x00000000,2).
- `rst`=1 during WAIT_DONE of the 2nd burst -> next cycle all outputs 0. A START issued while `rd_idle`=0 is held off until `rd_idle`=1, then restarts cleanly.

Source files
------------

// File: rtl/axi_sched_pkg.sv
// Shared types and constants for the AXI read burst scheduler.
package axi_sched_pkg;

  localparam int BOUNDARY_BYTES = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH
  } state_t;

  // Shift that converts a beat count into a byte count.
  function automatic int byte_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/burst_len_calc.sv
// Combinational burst length: min(MAX_BURST, remaining beats, beats to the 4 KB boundary).
module burst_len_calc
  import axi_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 16
) (
  input  logic [11:0] cur_addr,   // byte offset within the current 4 KB page
  input  logic [31:0] rem,
  output logic [31:0] blen
);

  localparam int SHIFT = byte_shift(DATA_WIDTH);

  logic [12:0] bytes_left;
  logic [12:0] btb;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    bytes_left = 13'(BOUNDARY_BYTES) - {1'b0, cur_addr};
    btb        = bytes_left >> SHIFT;
    blen       = 32'(MAX_BURST);
    if (rem < blen) blen = rem;
    if ({19'd0, btb} < blen) blen = {19'd0, btb};
  end

endmodule

// File: rtl/axi_rd_burst_sched.sv
// Splits one long read request into 4 KB-safe INCR bursts and sequences the read master.
module axi_rd_burst_sched
  import axi_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        START_REG,
  input  logic [31:0] ADDR_REG,
  input  logic [31:0] LENGTH_REG,
  output logic        BUSY_REG,
  output logic        DONE_REG,
  output logic [31:0] NBURST_REG,
  output logic [31:0] CYCLES_REG,
  output logic        rd_start,
  output logic [31:0] rd_addr,
  output logic [31:0] rd_len,
  input  logic        rd_idle
);

  localparam int          SHIFT     = byte_shift(DATA_WIDTH);
  localparam logic [31:0] ADDR_MASK = 32'((DATA_WIDTH / 8) - 1);

  state_t      state;
  logic        start_q;
  logic        pend;
  logic [31:0] cur_addr;
  logic [31:0] rem;
  logic [31:0] blen;
  logic        start_fire;

  burst_len_calc #(
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) u_len (
    .cur_addr(cur_addr[11:0]),
    .rem     (rem),
    .blen    (blen)
  );

  assign BUSY_REG = (state != S_IDLE) && (state != S_FINISH);
  assign DONE_REG = (state == S_FINISH);
  assign rd_start = (state == S_ISSUE) || (state == S_WAIT_ACK);

  // An edge that arrives while the read master is still busy stays pending until it idles.
  assign start_fire = START_REG && (!start_q || pend);

  // NOTE: sequential state uses non-blocking assignments only; later ones in the same edge win.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      start_q    <= 1'b1;   // a START held through reset must not fire
      pend       <= 1'b0;
      cur_addr   <= '0;
      rem        <= '0;
      rd_addr    <= '0;
      rd_len     <= '0;
      NBURST_REG <= '0;
      CYCLES_REG <= '0;
    end else begin
      start_q <= START_REG;
      if (BUSY_REG && CYCLES_REG != 32'hFFFF_FFFF) CYCLES_REG <= CYCLES_REG + 32'd1;

      case (state)
        S_IDLE: begin
          if (start_fire) begin
            if (rd_idle) begin
              pend  <= 1'b0;
              state <= S_LOAD;
            end else begin
              pend <= 1'b1;
            end
          end else if (!START_REG) begin
            pend <= 1'b0;
          end
        end
        S_LOAD: begin
          cur_addr   <= ADDR_REG & ~ADDR_MASK;
          rem        <= LENGTH_REG;
          NBURST_REG <= '0;
          CYCLES_REG <= 32'd1;   // LOAD itself is the first busy cycle
          state      <= (LENGTH_REG == '0) ? S_FINISH : S_CALC;
        end
        S_CALC: begin
          rd_addr <= cur_addr;
          rd_len  <= blen;
          state   <= S_ISSUE;
        end
        S_ISSUE:     state <= S_WAIT_ACK;
        S_WAIT_ACK:  if (!rd_idle) state <= S_WAIT_DONE;
        S_WAIT_DONE: if (rd_idle) state <= S_NEXT;
        S_NEXT: begin
          cur_addr   <= cur_addr + (rd_len << SHIFT);
          rem        <= rem - rd_len;
          NBURST_REG <= NBURST_REG + 32'd1;
          state      <= (rem == rd_len) ? S_FINISH : S_CALC;
        end
        S_FINISH:    if (!START_REG) state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

endmodule
